mac_psum_accumulator: RTL

MAC_PSUM_ACCUMULATOR -- requirements
Module: mac_psum_accumulator

---
 rtl/mac_psum_accumulator_if.sv | 23 ++
 rtl/mac_psum_accumulator.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mac_psum_accumulator_if.sv
// rtl/mac_psum_accumulator_if.sv - psum beat input and group-sum output handshake bundle
interface mac_psum_accumulator_if #(
  parameter int ACC_W = 6
);
  logic               clear_i;
  logic               psum_valid_i;
  logic               psum_ready_o;
  logic [31:0]        psum_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [8*ACC_W-1:0] out_data_o;
  logic [5:0]         beat_cnt_o;

  modport master (
    output clear_i, psum_valid_i, psum_i, out_ready_i,
    input  psum_ready_o, out_valid_o, out_data_o, beat_cnt_o
  );

  modport slave (
    input  clear_i, psum_valid_i, psum_i, out_ready_i,
    output psum_ready_o, out_valid_o, out_data_o, beat_cnt_o
  );
endinterface

// File: rtl/mac_psum_accumulator.sv
// rtl/mac_psum_accumulator.sv - sums NUM_TILES MAC result beats per lane; PSUM_SAT_EN selects saturating lanes instead of wrapping
module mac_psum_accumulator #(
  parameter int NUM_TILES = 4,
  parameter int ACC_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  mac_psum_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Counter value of the beat that closes a group; counter never reaches NUM_TILES.
  localparam logic [5:0] LP_LAST = 6'(NUM_TILES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [5:0]         r_beat_cnt;
  logic [ACC_W-1:0]   r_acc [8];
  logic [8*ACC_W-1:0] r_out_data;

  logic               w_out_valid;
  logic               w_psum_ready;
  logic               w_accept;
  logic               w_last;
  logic [ACC_W-1:0]   w_sum [8];
  logic [8*ACC_W-1:0] w_sum_flat;

  assign w_accept = bus.psum_valid_i && w_psum_ready;
  // In IDLE and HOLD the counter is 0, so this also covers the single-tile case.
  assign w_last   = (r_beat_cnt == LP_LAST);

  // Per-lane next sum: first beat of a group loads, later beats add.
  for (genvar g = 0; g < 8; g++) begin : g_lane
    logic [ACC_W-1:0] w_lane;
    logic [ACC_W-1:0] w_base;
    assign w_lane = ACC_W'(bus.psum_i[4*g +: 4]);
    assign w_base = (r_beat_cnt == 6'd0) ? '0 : r_acc[g];
`ifdef PSUM_SAT_EN
    logic [ACC_W:0] w_wide;
    assign w_wide   = {1'b0, w_base} + {1'b0, w_lane};
    // Once a lane hits all-ones it stays there: further adds only carry out again.
    assign w_sum[g] = w_wide[ACC_W] ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0];
`else
    assign w_sum[g] = w_base + w_lane;
`endif
    assign w_sum_flat[ACC_W*g +: ACC_W] = w_sum[g];
  end

  // State register; reset dominates clear and every handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; clear abandons any open group or pending result.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_state_nxt = w_last ? ST_HOLD : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_accept && w_last) begin
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready_i) begin
            if (w_accept) begin
              w_state_nxt = w_last ? ST_HOLD : ST_ACCUM;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode: result valid only in HOLD; input stalls while a result is unread.
  always_comb begin
    w_out_valid  = (r_state == ST_HOLD);
    w_psum_ready = (!w_out_valid || bus.out_ready_i) && !bus.clear_i && !rst;
  end

  // Lane accumulators, beat counter and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= 6'd0;
      r_out_data <= '0;
      for (int k = 0; k < 8; k++) begin
        r_acc[k] <= '0;
      end
    end else if (bus.clear_i) begin
      r_beat_cnt <= 6'd0;
    end else if (w_accept) begin
      if (w_last) begin
        r_beat_cnt <= 6'd0;
        r_out_data <= w_sum_flat;
      end else begin
        r_beat_cnt <= r_beat_cnt + 6'd1;
        for (int k = 0; k < 8; k++) begin
          r_acc[k] <= w_sum[k];
        end
      end
    end
  end

  assign bus.out_valid_o  = w_out_valid;
  assign bus.psum_ready_o = w_psum_ready;
  assign bus.out_data_o   = r_out_data;
  assign bus.beat_cnt_o   = r_beat_cnt;

endmodule
